dequantizer: RTL and testbench
==============================

# dequantizer

Dequantizes one 8x8 block of entropy-decoded JPEG coefficients and feeds it to the inverse cosine transformer over the `dq_*` interface. Input coefficients arrive in zigzag order. Each is multiplied by its quantization-table entry, converted to fixed point and tagged with its natural-order (row, col). An early end-of-block marker makes the block zero-fill the rest of the 64 positions.

## Interface
- `Q_BIT`, 32, width of `dq_veri_o` (signed fixed point)
- `Q_FRAC`, 16, fractional bits of `dq_veri_o`; integer part is `[Q_BIT-1:Q_FRAC]`
- `C_BIT`, 12, width of signed input coefficient
- `clk_i`  in  1  clock; one clock domain
- `rst_i`  in  1  reset, synchronous, active-high
- `hd_veri_i`  in  C_BIT  signed coefficient, zigzag order
- `hd_eob_i`  in  1  this beat is the last nonzero coefficient of the block
- `hd_gecerli_i`  in  1  input valid
- `hd_hazir_o`  out  1  input ready
- `qt_yaz_i`  in  1  quant-table write strobe
- `qt_adr_i`  in  6  table index (zigzag order)
- `qt_veri_i`  in  8  unsigned table value
- `dq_veri_o`  out  Q_BIT  dequantized coefficient
- `dq_row_o`  out  3  natural row
- `dq_col_o`  out  3  natural column
- `dq_gecerli_o`  out  1  output valid
- `dq_blok_son_o`  out  1  last coefficient (index 63) of block
- `dq_hazir_i`  in  1  downstream ready

## Operation
- Quant table: 64 x 8-bit registers. `qt_yaz_i` writes `qt_veri_i` to entry `qt_adr_i` on the clock edge.
- Zigzag counter `k` (6 bit) holds the index of the next coefficient to emit.
- Per emitted coefficient:
  - product `p = hd_veri_i * qt[k]` (signed x unsigned, 20-bit signed).
  - `p` saturates to [-2^(Q_BIT-Q_FRAC-1), 2^(Q_BIT-Q_FRAC-1)-1], which is [-32768, 32767] at default widths.
  - Result is placed in the integer field with the fraction bits set to 0.
- `(dq_row_o, dq_col_o)` come from the standard JPEG zigzag LUT of `k`: 0->(0,0), 1->(0,1), 2->(1,0), 3->(2,0), 4->(1,1), 5->(0,2), 63->(7,7).
- `dq_blok_son_o` = 1 exactly when the emitted beat has k=63.
- State machine:
  - AL (accept): `hd_hazir_o = !dq_gecerli_o || dq_hazir_i`. An input handshake loads the output register and increments `k`.
    - `hd_eob_i` on an accepted beat with k<63: go to DOLDUR.
    - k=63 accepted (with or without EOB): `k` wraps to 0 and the state stays AL.
  - DOLDUR (fill): `hd_hazir_o = 0`. Whenever the output register is free (`!dq_gecerli_o || dq_hazir_i`), load value 0 with the LUT position of `k` and increment `k`. After k=63 is loaded, return to AL with k=0.
- A table write to the same index read in the same cycle: the product uses the old value and the new value takes effect next cycle.
- Input values present while `hd_gecerli_i=0` are ignored. `hd_eob_i` is sampled only on a handshake.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is on `dq_*` after edge N.
- Throughput is 1 coefficient/cycle, in AL and DOLDUR alike. No bubble between a block end and the next block start.
- Output register holds (all `dq_*` stable) while `dq_gecerli_o && !dq_hazir_i`.
- `dq_gecerli_o` clears on an edge with `dq_hazir_i=1` and no new load.
- Reset values (synchronous, applied on the edge with `rst_i=1`):
  - `dq_gecerli_o=0`, `dq_blok_son_o=0`, `dq_veri_o=0`, `dq_row_o=0`, `dq_col_o=0`
  - `k=0`, state AL
  - all table entries = 1
  - `hd_hazir_o=1` after reset
- Reset mid-block or mid-fill discards the partial block, with no `dq_blok_son_o` for it. The next accepted beat is k=0.
- Exactly 64 `dq_*` handshakes per block, regardless of where EOB falls.

## Test plan
- Default table (all 1), 64 beats `hd_veri_i=k-32`, no EOB, `dq_hazir_i=1`:
  - `dq_veri_o[31:16]=k-32`, fraction 0
  - beat 5 at (0,2), beat 63 at (7,7) with `dq_blok_son_o=1`
  - one beat per cycle, 1-cycle latency
- Table loaded with qt[k]=k+1, input 2 each beat:
  - outputs 2(k+1)
  - second block with same table is identical; `k` wraps with no idle cycle
- Saturation:
  - qt[0]=255, `hd_veri_i=2047` -> integer 32767
  - qt[1]=255, `hd_veri_i=-2048` -> integer -32768
- EOB on beat k=2 (values 10, 20, 30, qt=1):
  - outputs 10, 20, 30, then 61 zero beats at LUT positions
  - `hd_hazir_o=0` throughout fill; last zero at (7,7) with `dq_blok_son_o=1`
- Random `dq_hazir_i` (50%) during a full block and an EOB fill:
  - no lost, duplicated or changed beats
  - outputs stable while stalled; 64 handshakes per block
- `rst_i` asserted at beat 20, and separately during fill:
  - next cycle `dq_gecerli_o=0`, state AL
  - next block starts at (0,0) and table reads back as 1

Source files
------------

// File: rtl/dequantizer.sv
// dequantizer: zigzag coefficient x quant table, saturated to Q_BIT fixed point with natural (row,col); hd_* coefficient in, qt_* table write, dq_* result out
module dequantizer #(
  parameter int Q_BIT = 32,
  parameter int Q_FRAC = 16,
  parameter int C_BIT = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [C_BIT-1:0] hd_veri_i,
  input  logic             hd_eob_i,
  input  logic             hd_gecerli_i,
  output logic             hd_hazir_o,
  input  logic             qt_yaz_i,
  input  logic [5:0]       qt_adr_i,
  input  logic [7:0]       qt_veri_i,
  output logic [Q_BIT-1:0] dq_veri_o,
  output logic [2:0]       dq_row_o,
  output logic [2:0]       dq_col_o,
  output logic             dq_gecerli_o,
  output logic             dq_blok_son_o,
  input  logic             dq_hazir_i
);
  localparam int IW = Q_BIT - Q_FRAC;
  localparam int PW = C_BIT + 9;
  localparam logic [0:0] AL = 1'b0;
  localparam logic [0:0] DOLDUR = 1'b1;
  localparam logic signed [IW-1:0] MAXV = {1'b0, {(IW-1){1'b1}}};
  localparam logic signed [IW-1:0] MINV = {1'b1, {(IW-1){1'b0}}};
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
  logic [7:0] qt [64];
  logic [5:0] k;
  logic [0:0] state;
  logic free, ld_in, ld_fill;
  logic signed [PW-1:0] p;
  logic signed [IW-1:0] sat;
  assign free = !dq_gecerli_o || dq_hazir_i;
  assign hd_hazir_o = state == AL && free;
  assign ld_in = hd_gecerli_i && hd_hazir_o;
  assign ld_fill = state == DOLDUR && free;
  always_comb begin
    p = PW'($signed(hd_veri_i)) * PW'($signed({1'b0, qt[k]}));
    sat = p > PW'(MAXV) ? MAXV : p < PW'(MINV) ? MINV : p[IW-1:0];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 64; i++) qt[i] <= 8'd1;
      k <= '0;
      state <= AL;
      dq_gecerli_o <= 1'b0;
      dq_blok_son_o <= 1'b0;
      dq_veri_o <= '0;
      dq_row_o <= '0;
      dq_col_o <= '0;
    end else begin
      if (qt_yaz_i) qt[qt_adr_i] <= qt_veri_i;
      if (ld_in || ld_fill) begin
        k <= k + 6'd1;
        dq_gecerli_o <= 1'b1;
        dq_veri_o <= ld_in ? {sat, {Q_FRAC{1'b0}}} : '0;
        {dq_row_o, dq_col_o} <= ZZ[k];
        dq_blok_son_o <= &k;
      end else if (dq_hazir_i) dq_gecerli_o <= 1'b0;
      if (ld_in && hd_eob_i && !(&k)) state <= DOLDUR;
      else if (ld_fill && &k) state <= AL;
    end
  end
endmodule

// File: tb/tb_dequantizer.sv
// tb_dequantizer: table vectors plus scoreboard-checked block sequences for dequantizer
module tb_dequantizer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_i, hd_eob_i, hd_gecerli_i, hd_hazir_o, qt_yaz_i;
  logic dq_gecerli_o, dq_blok_son_o;
  logic dq_hazir_i = 1'b1;
  logic [11:0] hd_veri_i;
  logic [5:0] qt_adr_i;
  logic [7:0] qt_veri_i;
  logic [31:0] dq_veri_o;
  logic [2:0] dq_row_o, dq_col_o;
  dequantizer dut (
    .clk_i(clk), .rst_i(rst_i), .hd_veri_i(hd_veri_i), .hd_eob_i(hd_eob_i),
    .hd_gecerli_i(hd_gecerli_i), .hd_hazir_o(hd_hazir_o), .qt_yaz_i(qt_yaz_i),
    .qt_adr_i(qt_adr_i), .qt_veri_i(qt_veri_i), .dq_veri_o(dq_veri_o),
    .dq_row_o(dq_row_o), .dq_col_o(dq_col_o), .dq_gecerli_o(dq_gecerli_o),
    .dq_blok_son_o(dq_blok_son_o), .dq_hazir_i(dq_hazir_i)
  );
  typedef struct {logic [31:0] v; logic [2:0] r; logic [2:0] c; logic son;} exp_t;
  typedef struct {int q; int d; int ex;} vec_t;
  exp_t sb[$];
  exp_t e;
  vec_t tv[8];
  int n_vec = 0, n_bad = 0, hs = 0, cyc = 0, km = 0;
  int zr[64], zc[64], qm[64];
  bit stall_rand = 0, fill_chk = 0, prev_stall = 0;
  logic [38:0] prev, cur;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    dq_hazir_i = stall_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask
  function automatic int satf(int v);
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
  endfunction
  always @(negedge clk) begin
    cur = {dq_veri_o, dq_row_o, dq_col_o, dq_blok_son_o};
    if (rst_i) prev_stall = 0;
    else begin
      if (prev_stall) chk("hold_while_stalled", 64'(cur), 64'(prev));
      if (fill_chk && dq_gecerli_o && !dq_blok_son_o) chk("hazir_during_fill", 64'(hd_hazir_o), 64'(0));
      if (dq_gecerli_o && dq_hazir_i) begin
        hs++;
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL extra_beat: got %0h at (%0d,%0d), required no beat", dq_veri_o, dq_row_o, dq_col_o);
        end else begin
          e = sb.pop_front();
          chk("data", 64'(dq_veri_o), 64'(e.v));
          chk("row_col", 64'({dq_row_o, dq_col_o}), 64'({e.r, e.c}));
          chk("blok_son", 64'(dq_blok_son_o), 64'(e.son));
        end
      end
      prev_stall = dq_gecerli_o && !dq_hazir_i;
      prev = cur;
    end
  end
  task automatic put(int d, bit eob, int ex);
    int t = 0;
    hd_veri_i = d[11:0];
    hd_eob_i = eob;
    hd_gecerli_i = 1'b1;
    @(negedge clk);
    while (!hd_hazir_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!hd_hazir_o) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: hd_hazir_o low for %0d cycles, required high", t);
    end else begin
      sb.push_back('{32'(ex * 65536), 3'(zr[km]), 3'(zc[km]), km == 63});
      if (eob && km < 63)
        for (int j = km + 1; j < 64; j++) sb.push_back('{32'd0, 3'(zr[j]), 3'(zc[j]), j == 63});
      km = (eob || km == 63) ? 0 : km + 1;
    end
    @(posedge clk);
    #1;
    hd_gecerli_i = 1'b0;
    hd_eob_i = 1'b0;
  endtask
  task automatic put_m(int d, bit eob);
    put(d, eob, satf(d * qm[km]));
  endtask
  task automatic wq(int a, int v);
    qt_yaz_i = 1'b1;
    qt_adr_i = a[5:0];
    qt_veri_i = v[7:0];
    @(posedge clk);
    #1;
    qt_yaz_i = 1'b0;
    qm[a] = v;
  endtask
  task automatic drain;
    int t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_i = 1'b1;
    hd_gecerli_i = 1'b0;
    hd_eob_i = 1'b0;
    qt_yaz_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    sb.delete();
    km = 0;
    fill_chk = 0;
    for (int i = 0; i < 64; i++) qm[i] = 1;
    chk("rst_gecerli", 64'(dq_gecerli_o), 64'(0));
    chk("rst_blok_son", 64'(dq_blok_son_o), 64'(0));
    chk("rst_veri", 64'(dq_veri_o), 64'(0));
    chk("rst_row_col", 64'({dq_row_o, dq_col_o}), 64'(0));
    chk("rst_hazir", 64'(hd_hazir_o), 64'(1));
  endtask
  initial begin
    int r, c, h0, c0;
    tv[0] = '{255, 2047, 32767};
    tv[1] = '{255, -2048, -32768};
    tv[2] = '{3, -5, -15};
    tv[3] = '{200, 100, 20000};
    tv[4] = '{0, 77, 0};
    tv[5] = '{128, -256, -32768};
    tv[6] = '{128, 256, 32767};
    tv[7] = '{129, 254, 32766};
    r = 0;
    c = 0;
    for (int i = 0; i < 64; i++) begin
      zr[i] = r;
      zc[i] = c;
      if ((r + c) % 2 == 0) begin
        if (c == 7) r++;
        else if (r == 0) c++;
        else begin r--; c++; end
      end else begin
        if (r == 7) c++;
        else if (c == 0) r++;
        else begin r++; c--; end
      end
    end
    rst_i = 1'b0;
    hd_gecerli_i = 1'b0;
    hd_eob_i = 1'b0;
    hd_veri_i = '0;
    qt_yaz_i = 1'b0;
    qt_adr_i = '0;
    qt_veri_i = '0;
    @(posedge clk);
    #1;
    do_reset;
    h0 = hs;
    put_m(-32, 0);
    chk("latency_valid", 64'(dq_gecerli_o), 64'(1));
    chk("latency_data", 64'(dq_veri_o), 64'(32'hFFE0_0000));
    c0 = cyc;
    for (int i = 1; i < 64; i++) put_m(i - 32, 0);
    chk("throughput_block", 64'(cyc - c0), 64'(63));
    drain;
    chk("handshakes_plain", 64'(hs - h0), 64'(64));
    for (int i = 0; i < 64; i++) wq(i, i + 1);
    h0 = hs;
    c0 = cyc;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 64; i++) begin
        if (b == 1 && i == 3) begin
          qt_yaz_i = 1'b1;
          qt_adr_i = 6'd3;
          qt_veri_i = 8'd9;
        end
        put_m(2, 0);
        if (b == 1 && i == 3) begin
          qt_yaz_i = 1'b0;
          qm[3] = 9;
        end
      end
    chk("throughput_two_blocks", 64'(cyc - c0), 64'(128));
    drain;
    chk("handshakes_two_blocks", 64'(hs - h0), 64'(128));
    for (int i = 0; i < 8; i++) wq(i, tv[i].q);
    h0 = hs;
    for (int i = 0; i < 8; i++) put(tv[i].d, i == 7, tv[i].ex);
    fill_chk = 1;
    drain;
    fill_chk = 0;
    chk("handshakes_vectors", 64'(hs - h0), 64'(64));
    for (int i = 0; i < 20; i++) put_m(i - 32, 0);
    do_reset;
    h0 = hs;
    put_m(10, 0);
    put_m(20, 0);
    put_m(30, 1);
    fill_chk = 1;
    drain;
    fill_chk = 0;
    chk("handshakes_eob", 64'(hs - h0), 64'(64));
    stall_rand = 1;
    for (int i = 0; i < 10; i++) wq(i * 6, 3 + i * 20);
    h0 = hs;
    for (int i = 0; i < 64; i++) put_m(i * 13 - 400, 0);
    drain;
    chk("handshakes_stall_full", 64'(hs - h0), 64'(64));
    h0 = hs;
    for (int i = 0; i < 10; i++) put_m(i * 91 - 700, i == 9);
    fill_chk = 1;
    drain;
    fill_chk = 0;
    chk("handshakes_stall_eob", 64'(hs - h0), 64'(64));
    stall_rand = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) put_m(i + 1, 0);
    put_m(7, 1);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    do_reset;
    h0 = hs;
    for (int i = 0; i < 64; i++) put_m(i - 32, 0);
    drain;
    chk("handshakes_after_fill_reset", 64'(hs - h0), 64'(64));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
